// File: rtl/bias_group_sequencer_l17.sv
// Layer-17 bias sequencer: walks the bias-mux select z through 16 groups,
// registers each group's bias vector and gates pixel accumulation per group.
//
// state | meaning
// IDLE  | waiting for start; z=0, pix_cnt=0
// LOAD  | one cycle for the bias mux to settle on z; bias_q captured on exit
// RUN   | accepting pixels for group z until N_PIX have been taken
// DONE  | layer finished; single-cycle layer_done, then back to IDLE
module bias_group_sequencer_l17 #(
    parameter int N_adder_tree = 16,
    parameter int N_PIX        = 196,
    parameter int PIX_W        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_adder_tree*18-1:0]   BIAS,
    input  logic                         px_valid,
    output logic                         px_ready,
    output logic [3:0]                   z,
    output logic [N_adder_tree*18-1:0]   bias_q,
    output logic                         bias_q_valid,
    output logic [PIX_W-1:0]             pix_cnt,
    output logic                         group_done,
    output logic                         layer_done,
    output logic                         busy
);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);
    localparam logic [3:0]       Z_LAST   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic pix_last;

    assign accept   = (state == S_RUN) && px_valid;
    assign pix_last = accept && (pix_cnt == PIX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = S_LOAD;
                S_LOAD: state_nxt = S_RUN;
                S_RUN: begin
                    if (pix_last) begin
                        state_nxt = (z == Z_LAST) ? S_DONE : S_LOAD;
                    end
                end
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        px_ready     = 1'b0;
        bias_q_valid = 1'b0;
        layer_done   = 1'b0;
        busy         = 1'b1;
        case (state)
            S_IDLE: busy = 1'b0;
            S_RUN: begin
                px_ready     = 1'b1;
                bias_q_valid = 1'b1;
            end
            S_DONE: layer_done = 1'b1;
            default: ;
        endcase
    end

    // z only moves when leaving RUN, so the mux has the whole LOAD cycle to settle
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            z <= 4'd0;
        end else if (state == S_DONE) begin
            z <= 4'd0;
        end else if (pix_last && (z != Z_LAST)) begin
            z <= z + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            pix_cnt <= '0;
        end else if (pix_last) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            group_done <= 1'b0;
        end else begin
            group_done <= pix_last;
        end
    end

    // an aborted LOAD leaves the previously captured bias in place
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q <= '0;
        end else if ((state == S_LOAD) && !abort) begin
            bias_q <= BIAS;
        end
    end

endmodule

// File: tb/tb_bias_group_sequencer_l17.sv
// Bench for bias_group_sequencer_l17: behavioural layer model checked every
// cycle, directed timing scenarios with literal expectations, then random traffic.
module tb_bias_group_sequencer_l17;

    localparam int NAT  = 16;
    localparam int NPIX = 4;
    localparam int PW   = 8;
    localparam int BW   = NAT * 18;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [BW-1:0] bias_in;
    logic          px_valid;
    logic          px_ready;
    logic [3:0]    z;
    logic [BW-1:0] bias_q;
    logic          bias_q_valid;
    logic [PW-1:0] pix_cnt;
    logic          group_done;
    logic          layer_done;
    logic          busy;
    logic [17:0]   salt;

    int vectors;
    int miscompares;

    bias_group_sequencer_l17 #(
        .N_adder_tree(NAT),
        .N_PIX(NPIX),
        .PIX_W(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .BIAS(bias_in),
        .px_valid(px_valid),
        .px_ready(px_ready),
        .z(z),
        .bias_q(bias_q),
        .bias_q_valid(bias_q_valid),
        .pix_cnt(pix_cnt),
        .group_done(group_done),
        .layer_done(layer_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pat(input int g, input logic [17:0] s);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < NAT; i++) r[i*18 +: 18] = 18'(g + 1) ^ s;
        return r;
    endfunction

    always_comb bias_in = pat(int'(z), salt);

    // layer model: in_layer / loading / finished flags, group index, pixel tally
    bit            m_in_layer;
    bit            m_loading;
    bit            m_finished;
    int            m_g;
    int            m_cnt;
    bit            m_gd;
    logic [BW-1:0] m_bias;

    task automatic model_step();
        bit gd;
        if (rst) begin
            m_in_layer = 0; m_loading = 0; m_finished = 0;
            m_g = 0; m_cnt = 0; m_gd = 0; m_bias = '0;
        end else if (abort) begin
            m_in_layer = 0; m_loading = 0; m_finished = 0;
            m_g = 0; m_cnt = 0; m_gd = 0;
        end else begin
            gd = 0;
            if (!m_in_layer) begin
                if (start) begin
                    m_in_layer = 1; m_loading = 1; m_g = 0;
                end
            end else if (m_finished) begin
                m_in_layer = 0; m_finished = 0; m_g = 0;
            end else if (m_loading) begin
                m_bias = pat(m_g, salt);
                m_loading = 0;
            end else if (px_valid) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == NPIX) begin
                    m_cnt = 0;
                    gd = 1;
                    if (m_g == 15) m_finished = 1;
                    else begin
                        m_g = m_g + 1;
                        m_loading = 1;
                    end
                end
            end
            m_gd = gd;
        end
    endtask

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit running;
        running = m_in_layer && !m_loading && !m_finished;
        chk("z", BW'(z), BW'(m_g));
        chk("pix_cnt", BW'(pix_cnt), BW'(m_cnt));
        chk("px_ready", BW'(px_ready), BW'(running));
        chk("bias_q_valid", BW'(bias_q_valid), BW'(running));
        chk("group_done", BW'(group_done), BW'(m_gd));
        chk("layer_done", BW'(layer_done), BW'(m_finished));
        chk("busy", BW'(busy), BW'(m_in_layer));
        chk("bias_q", bias_q, m_bias);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    int ld_k, idle_k, gd_cnt, gd1, gd2, ld_cnt, rises;
    bit prev_busy;

    task automatic run_full_layer(input string tag);
        px_valid = 1'b1;
        salt = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_k = -1; idle_k = -1; gd_cnt = 0;
        for (int k = 1; k <= 90; k++) begin
            if (layer_done && ld_k < 0) ld_k = k;
            if (!busy && idle_k < 0) idle_k = k;
            if (group_done) gd_cnt++;
            if (k == 76) chk({tag, "_z_last_group"}, BW'(z), BW'(15));
            if (k == 81) chk({tag, "_model_done81"}, BW'(m_finished), BW'(1));
            tick();
        end
        chk({tag, "_layer_done_cycle"}, BW'(ld_k), BW'(81));
        chk({tag, "_idle_cycle"}, BW'(idle_k), BW'(82));
        chk({tag, "_group_done_count"}, BW'(gd_cnt), BW'(16));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; px_valid = 1'b0; salt = '0;
        m_in_layer = 0; m_loading = 0; m_finished = 0;
        m_g = 0; m_cnt = 0; m_gd = 0; m_bias = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", BW'(busy), BW'(0));
        chk("reset_bias_q", bias_q, '0);
        chk("reset_px_ready", BW'(px_ready), BW'(0));
        tick();

        run_full_layer("full");

        // px_valid alternating 1,0,... from each LOAD: 8 RUN cycles per group
        start = 1'b1;
        tick();
        start = 1'b0;
        gd1 = -1; gd2 = -1; ld_k = -1;
        for (int k = 1; k <= 160; k++) begin
            if (group_done) begin
                if (gd1 < 0) gd1 = k;
                else if (gd2 < 0) gd2 = k;
            end
            if (layer_done && ld_k < 0) ld_k = k;
            px_valid = (((k - 1) % 9) % 2) == 0;
            tick();
        end
        chk("toggle_gd1", BW'(gd1), BW'(10));
        chk("toggle_gd2", BW'(gd2), BW'(19));
        chk("toggle_layer_done", BW'(ld_k), BW'(145));

        // abort in RUN of group 7 with pix_cnt==2
        px_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 39) begin
                chk("abort_pre_z", BW'(z), BW'(7));
                chk("abort_pre_cnt", BW'(pix_cnt), BW'(2));
            end
            if (k == 40) begin
                chk("abort_busy", BW'(busy), BW'(0));
                chk("abort_z", BW'(z), BW'(0));
                chk("abort_cnt", BW'(pix_cnt), BW'(0));
                chk("abort_gd", BW'(group_done), BW'(0));
                chk("abort_ld", BW'(layer_done), BW'(0));
                chk("abort_bias_hold", bias_q, pat(7, 18'd0));
            end
            abort = (k == 39);
            tick();
        end
        abort = 1'b0;
        run_full_layer("after_abort");

        // reset during LOAD of group 3
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 16) chk("rst_load_z", BW'(z), BW'(3));
            if (k == 17) begin
                chk("rst_busy", BW'(busy), BW'(0));
                chk("rst_z", BW'(z), BW'(0));
                chk("rst_bias_q", bias_q, '0);
                chk("rst_bias_valid", BW'(bias_q_valid), BW'(0));
                chk("rst_cnt", BW'(pix_cnt), BW'(0));
            end
            rst = (k == 16);
            tick();
        end
        rst = 1'b0;

        // start held high through DONE and the following IDLE: one restart
        start = 1'b1;
        tick();
        ld_cnt = 0; rises = 0; prev_busy = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            if (layer_done) ld_cnt++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
            if (k == 82) chk("hold_idle_busy", BW'(busy), BW'(0));
            if (k == 83) begin
                chk("hold_restart_busy", BW'(busy), BW'(1));
                chk("hold_restart_z", BW'(z), BW'(0));
            end
            if (k > 82) start = 1'b0;
            tick();
        end
        chk("hold_layer_done_count", BW'(ld_cnt), BW'(2));
        chk("hold_restart_count", BW'(rises), BW'(1));

        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom % 300) == 0;
            abort    = ($urandom % 150) == 0;
            start    = ($urandom % 5) == 0;
            px_valid = ($urandom % 4) != 0;
            salt     = 18'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bias_group_sequencer_l17.md
# bias_group_sequencer_l17

Layer-17 bias sequencer: drives the 4-bit select `z` of the layer's 16:1 bias multiplexer through all 16 output-channel groups. Per group it registers the selected `N_adder_tree*18`-bit bias vector for the adder tree and gates a pixel-accumulation handshake until `N_PIX` results are consumed. It signals per-group and per-layer completion to the layer controller. It sits between the layer FSM, the bias mux and the adder-tree output stage.

## Interface
- `N_adder_tree`, 16, adder-tree lanes; bias vector width = `N_adder_tree*18`
- `N_PIX`, 196, pixels accumulated per group (≥1)
- `PIX_W`, 8, pixel counter width (2^PIX_W ≥ N_PIX)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin layer; sampled only in IDLE
- `abort`  in  1  synchronous cancel; any state → IDLE next cycle
- `BIAS`  in  `N_adder_tree*18`  combinational bias-mux output for current `z`
- `px_valid`  in  1  datapath has an accumulated pixel for the current group
- `px_ready`  out  1  controller accepts pixel (high only in RUN)
- `z`  out  4  bias-mux select = current group index
- `bias_q`  out  `N_adder_tree*18`  registered bias for adder tree
- `bias_q_valid`  out  1  `bias_q` valid for current group (high in RUN)
- `pix_cnt`  out  `PIX_W`  pixels accepted in current group
- `group_done`  out  1  one-cycle pulse after last pixel of a group
- `layer_done`  out  1  one-cycle pulse after group 15 completes
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: `z`=0, `pix_cnt`=0. `start`=1 → LOAD.
- LOAD (exactly 1 cycle): `z` is stable. At the end of the cycle, `bias_q` ← `BIAS`. → RUN.
- RUN: `px_ready`=1 and `bias_q_valid`=1.
  - Each cycle with `px_valid`&`px_ready` is an accept; `pix_cnt` increments.
  - Accept while `pix_cnt`==`N_PIX`-1: `pix_cnt`←0 and `group_done` pulses next cycle.
  - If `z`<15 on that accept: `z`←`z`+1 and → LOAD.
  - If `z`==15 on that accept: → DONE (`z` holds at 15).
- DONE (1 cycle): `layer_done`=1, `busy`=1. → IDLE, where `z`←0.
- `start` outside IDLE is ignored.
- `abort` takes priority over all transitions. Next cycle: IDLE, `z`=0, `pix_cnt`=0, no `group_done`/`layer_done` pulse. `bias_q` holds its value.
- `rst` takes priority over `abort`. It forces the reset values listed under Timing.
- `px_valid` outside RUN is not accepted and has no effect.
- `z` never exceeds 15. There is no wrap from 15 to 0 except via DONE→IDLE, abort or reset.

## Timing
- Reset values: `z`=0, `bias_q`=0, `bias_q_valid`=0, `px_ready`=0, `pix_cnt`=0, `group_done`=0, `layer_done`=0, `busy`=0, state IDLE.
- `start` sampled at edge t → LOAD during t+1 → RUN from t+2. The first accept is possible at t+2.
- `z` changes only at the edge leaving RUN. Combined with the 1-cycle LOAD, the mux always has a full cycle to settle before `bias_q` captures.
- The last accept of group g at cycle c gives:
  - `group_done`=1 at c+1,
  - `z`=g+1 and LOAD at c+1,
  - RUN again at c+2.
- At full throughput, the layer occupies 16·(`N_PIX`+1) cycles from the first LOAD. `layer_done` is high in the cycle following the 16th `group_done` cycle's RUN exit (the same cycle as the final `group_done`). IDLE follows one cycle later.
- A `start` held high in the DONE cycle does not restart. A `start` high in the following IDLE cycle does.

## Test plan
- `N_PIX`=4, `px_valid` tied 1, `start` pulse at cycle 0 → `z` steps 0..15, each held 5 cycles. `group_done` fires 16×, spaced 5 cycles. One `layer_done` at cycle 81, `busy` low at cycle 82.
- Drive `BIAS` = {16{18'(z+1)}} combinationally from `z` → in each RUN, `bias_q` equals the pattern for the current `z`, never the previous group's value.
- `px_valid` toggling 1,0,1,0 → `pix_cnt` advances only on accepts. Group length doubles to 8 RUN cycles. No accepts occur during LOAD.
- `abort` asserted in RUN of group 7 with `pix_cnt`=2 → next cycle IDLE, `z`=0, `pix_cnt`=0, no `group_done`/`layer_done`. A new `start` then runs all 16 groups from 0.
- `rst` asserted in LOAD of group 3 → all outputs at reset values the next cycle. `start` held high through DONE → exactly one restart, from the IDLE cycle.
- `start` pulsed during RUN → ignored; the group count and `z` sequence are unaffected.
